// File: rtl/stmt_lowerer_rr_arbiter.sv
// Round-robin arbiter with grant hold; 1-cycle req->gnt latency, forced 1-cycle bubble after every release.
// Optional hold timeout enabled by defining STMT_LOWERER_ARB_TIMEOUT_EN.
module stmt_lowerer_rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       done,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       gnt_valid,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
    output logic                       timeout
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W:0]       NREQ_W   = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_REQ-1);
    localparam logic [NUM_REQ-1:0]   ONE_HOT0 = NUM_REQ'(1);

    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("NUM_REQ must be >= 2");
    end
    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("MAX_HOLD must be >= 1");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] next_ptr;
    logic [IDX_W:0]   cand;
    logic             found;
    logic             release_now;
    logic             hold_expired;

`ifdef STMT_LOWERER_ARB_TIMEOUT_EN
    localparam int HC_W = $clog2(MAX_HOLD+1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD-1);
    logic [HC_W-1:0] hold_cnt;
    logic            timeout_q;
    assign hold_expired = (hold_cnt == HOLD_LAST);
    assign timeout      = timeout_q;
`else
    assign hold_expired = 1'b0;
    assign timeout      = 1'b0;
`endif

    // First requester at or after ptr, wrapping by subtraction so non-pow2 sizes work.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + k[IDX_W:0];
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (req[cand[IDX_W-1:0]]) begin
                found   = 1'b1;
                win_idx = cand[IDX_W-1:0];
                break;
            end
        end
    end

    assign release_now = done | ~req[gnt_idx];
    assign next_ptr    = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            ptr       <= '0;
`ifdef STMT_LOWERER_ARB_TIMEOUT_EN
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef STMT_LOWERER_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= GRANT;
                        gnt       <= ONE_HOT0 << win_idx;
                        gnt_valid <= 1'b1;
                        gnt_idx   <= win_idx;
`ifdef STMT_LOWERER_ARB_TIMEOUT_EN
                        hold_cnt  <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (release_now || hold_expired) begin
                        state     <= IDLE;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        gnt_idx   <= '0;
                        ptr       <= next_ptr;
`ifdef STMT_LOWERER_ARB_TIMEOUT_EN
                        // A normal release on the expiry cycle wins, so no pulse then.
                        timeout_q <= ~release_now;
`endif
                    end else begin
`ifdef STMT_LOWERER_ARB_TIMEOUT_EN
                        hold_cnt  <= hold_cnt + HC_W'(1);
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_stmt_lowerer_rr_arbiter.sv
// Directed table-driven bench for stmt_lowerer_rr_arbiter (NUM_REQ=4 and NUM_REQ=3 instances).
module tb_stmt_lowerer_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_idx;
    logic       timeout;

    logic       rst3 = 1'b1;
    logic [2:0] req3 = 3'b000;
    logic       done3 = 1'b0;
    logic [2:0] gnt3;
    logic       gnt_valid3;
    logic [1:0] gnt_idx3;
    logic       timeout3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stmt_lowerer_rr_arbiter #(.NUM_REQ(4), .MAX_HOLD(8)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt), .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .timeout(timeout)
    );

    stmt_lowerer_rr_arbiter #(.NUM_REQ(3), .MAX_HOLD(8)) dut3 (
        .clk(clk), .rst(rst3), .req(req3), .done(done3),
        .gnt(gnt3), .gnt_valid(gnt_valid3), .gnt_idx(gnt_idx3), .timeout(timeout3)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic       vld;
        logic [1:0] idx;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [3:0] q, input logic d,
                       input logic [3:0] g, input logic v, input logic [1:0] x);
        vec_t e;
        e.rst = r; e.req = q; e.done = d; e.gnt = g; e.vld = v; e.idx = x;
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset, idle, done-in-idle
        add(1, 4'b0000, 0, 4'b0000, 0, 0);
        add(1, 4'b0000, 0, 4'b0000, 0, 0);
        add(0, 4'b0000, 0, 4'b0000, 0, 0);
        add(0, 4'b0000, 1, 4'b0000, 0, 0);
        // 1010 from ptr 0, release, then ptr 2 picks 3
        add(0, 4'b1010, 0, 4'b0010, 1, 1);
        add(0, 4'b1010, 0, 4'b0010, 1, 1);
        add(0, 4'b1010, 1, 4'b0000, 0, 0);
        add(0, 4'b1010, 0, 4'b1000, 1, 3);
        add(0, 4'b1010, 1, 4'b0000, 0, 0);
        // all requesting with done held: 0,1,2,3,0 with bubbles
        add(0, 4'b1111, 1, 4'b0001, 1, 0);
        add(0, 4'b1111, 1, 4'b0000, 0, 0);
        add(0, 4'b1111, 1, 4'b0010, 1, 1);
        add(0, 4'b1111, 1, 4'b0000, 0, 0);
        add(0, 4'b1111, 1, 4'b0100, 1, 2);
        add(0, 4'b1111, 1, 4'b0000, 0, 0);
        add(0, 4'b1111, 1, 4'b1000, 1, 3);
        add(0, 4'b1111, 1, 4'b0000, 0, 0);
        add(0, 4'b1111, 1, 4'b0001, 1, 0);
        add(0, 4'b0000, 0, 4'b0000, 0, 0);
        // ptr=1: holder 2, other bits ignored, drop+done together -> ptr 3
        add(0, 4'b0100, 0, 4'b0100, 1, 2);
        add(0, 4'b0111, 0, 4'b0100, 1, 2);
        add(0, 4'b0011, 1, 4'b0000, 0, 0);
        add(0, 4'b1001, 0, 4'b1000, 1, 3);
        // reset mid-grant -> ptr 0
        add(1, 4'b1001, 0, 4'b0000, 0, 0);
        add(0, 4'b1001, 0, 4'b0001, 1, 0);
        add(0, 4'b0000, 0, 4'b0000, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst  = tbl[i].rst;
            req  = tbl[i].req;
            done = tbl[i].done;
            tick();
            chk($sformatf("row%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            chk($sformatf("row%0d_vld", i), 32'(gnt_valid), 32'(tbl[i].vld));
            chk($sformatf("row%0d_idx", i), 32'(gnt_idx), 32'(tbl[i].idx));
            chk($sformatf("row%0d_timeout", i), 32'(timeout), 32'd0);
        end

        // hold with done=0 from ptr 1; only requester 0 asks
        req  = 4'b0001;
        done = 1'b0;
`ifdef STMT_LOWERER_ARB_TIMEOUT_EN
        for (int c = 1; c <= 10; c++) begin
            tick();
            chk($sformatf("to_c%0d_vld", c), 32'(gnt_valid), (c == 9) ? 32'd0 : 32'd1);
            chk($sformatf("to_c%0d_gnt", c), 32'(gnt), (c == 9) ? 32'd0 : 32'd1);
            chk($sformatf("to_c%0d_pulse", c), 32'(timeout), (c == 9) ? 32'd1 : 32'd0);
        end
`else
        for (int c = 1; c <= 20; c++) begin
            tick();
            chk($sformatf("hold_c%0d_vld", c), 32'(gnt_valid), 32'd1);
            chk($sformatf("hold_c%0d_gnt", c), 32'(gnt), 32'd1);
            chk($sformatf("hold_c%0d_timeout", c), 32'(timeout), 32'd0);
        end
`endif
        req = 4'b0000;
        tick();
        chk("hold_release_vld", 32'(gnt_valid), 32'd0);

        // NUM_REQ=3: move ptr to 2, then wrap search to 0, release -> ptr 1
        tick();
        rst3 = 1'b0;
        req3 = 3'b010;
        tick();
        chk("n3_g1_gnt", 32'(gnt3), 32'b010);
        chk("n3_g1_idx", 32'(gnt_idx3), 32'd1);
        req3 = 3'b000;
        tick();
        chk("n3_rel1_vld", 32'(gnt_valid3), 32'd0);
        req3 = 3'b001;
        tick();
        chk("n3_wrap_gnt", 32'(gnt3), 32'b001);
        chk("n3_wrap_idx", 32'(gnt_idx3), 32'd0);
        req3 = 3'b000;
        tick();
        chk("n3_rel2_gnt", 32'(gnt3), 32'd0);
        req3 = 3'b111;
        tick();
        chk("n3_ptr1_gnt", 32'(gnt3), 32'b010);
        chk("n3_ptr1_idx", 32'(gnt_idx3), 32'd1);
        done3 = 1'b1;
        tick();
        chk("n3_rel3_vld", 32'(gnt_valid3), 32'd0);
        tick();
        chk("n3_ptr2_gnt", 32'(gnt3), 32'b100);
        chk("n3_ptr2_idx", 32'(gnt_idx3), 32'd2);
        tick();
        tick();
        chk("n3_wrap3_gnt", 32'(gnt3), 32'b001);
        chk("n3_timeout", 32'(timeout3), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
